// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } state_e;

    localparam int MD_WIDTH = 32;
    localparam logic [MD_WIDTH-1:0] DIVZERO_LO = '1;
    localparam int CNT_W = $clog2(MD_WIDTH);

    function automatic logic op_is_div(input op_e o);
        return o[1];
    endfunction

    function automatic logic op_is_signed(input op_e o);
        return ~o[0];
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative datapath: shift-add multiply / restoring divide on magnitudes,
// with sign fix-up presented combinationally on res_hi/res_lo.
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  op_e              op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               is_div;
    logic               neg_lo;
    logic               neg_hi;
    logic               raw;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;

    always_comb begin
        a_neg = op_is_signed(op) & srca[WIDTH-1];
        b_neg = op_is_signed(op) & srcb[WIDTH-1];
        mag_a = a_neg ? (~srca + 1'b1) : srca;
        mag_b = b_neg ? (~srcb + 1'b1) : srcb;
    end

    // Multiply: add multiplicand into the upper half when the low bit is set, then shift right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    // Divide: shift the remainder/quotient pair left and subtract the divisor if it fits.
    logic [WIDTH:0]     sh_rem;
    logic               fits;
    logic [WIDTH-1:0]   sub_rem;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};
        sh_rem   = acc[2*WIDTH-1:WIDTH-1];
        fits     = (sh_rem >= {1'b0, opnd});
        sub_rem  = sh_rem[WIDTH-1:0] - opnd;
        div_next = fits ? {sub_rem, acc[WIDTH-2:0], 1'b1}
                        : {sh_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            raw    <= 1'b0;
        end else if (load) begin
            is_div <= op_is_div(op);
            if (op_is_div(op) && srcb == '0) begin
                acc    <= {srca, {WIDTH{1'b1}}};
                opnd   <= '0;
                raw    <= 1'b1;
                neg_lo <= 1'b0;
                neg_hi <= 1'b0;
            end else if (op_is_div(op)) begin
                acc    <= {{WIDTH{1'b0}}, mag_a};
                opnd   <= mag_b;
                raw    <= 1'b0;
                neg_lo <= a_neg ^ b_neg;
                neg_hi <= a_neg;
            end else begin
                acc    <= {{WIDTH{1'b0}}, mag_b};
                opnd   <= mag_a;
                raw    <= 1'b0;
                neg_lo <= a_neg ^ b_neg;
                neg_hi <= a_neg ^ b_neg;
            end
        end else if (step) begin
            acc <= is_div ? div_next : mul_next;
        end
    end

    logic [2*WIDTH-1:0] prod_neg;

    always_comb begin
        prod_neg = ~acc + 1'b1;
        res_hi   = acc[2*WIDTH-1:WIDTH];
        res_lo   = acc[WIDTH-1:0];
        if (!raw) begin
            if (is_div) begin
                if (neg_lo) res_lo = ~acc[WIDTH-1:0] + 1'b1;
                if (neg_hi) res_hi = ~acc[2*WIDTH-1:WIDTH] + 1'b1;
            end else if (neg_lo) begin
                res_hi = prod_neg[2*WIDTH-1:WIDTH];
                res_lo = prod_neg[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// MIPS HI/LO multiply/divide unit: sequencing FSM, iteration counter, stall and HI/LO registers.
// Ops take ITER+1 cycles of busy (divide-by-zero takes one); a busy unit stalls new ops and HI/LO accesses.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             hilo_req,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    state_e           state;
    logic [CW-1:0]    cnt;
    op_e              op_in;
    logic             divzero;
    logic             load;
    logic             step;
    logic [WIDTH-1:0] res_hi, res_lo;

    assign op_in   = op_e'(op);
    assign divzero = op_is_div(op_in) && (srcb == '0);
    assign busy    = (state != IDLE);
    assign stall   = busy & (start | hilo_req);
    assign load    = (state == IDLE) & start & ~flush;
    assign step    = ((state == MUL) | (state == DIV)) & ~flush;

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .op     (op_in),
        .srca   (srca),
        .srcb   (srcb),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            // A squash abandons the op and any HI/LO move issued alongside it.
            if (flush) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            cnt   <= '0;
                            state <= divzero ? FIX : (op_is_div(op_in) ? DIV : MUL);
                        end else begin
                            if (wr_hi) hi <= wdata;
                            if (wr_lo) lo <= wdata;
                        end
                    end
                    MUL, DIV: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(ITER - 1)) state <= FIX;
                    end
                    FIX: begin
                        hi    <= res_hi;
                        lo    <= res_lo;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srca, srcb;
    logic        hilo_req, wr_hi, wr_lo;
    logic [31:0] wdata;
    logic        flush;
    logic        busy, stall, done;
    logic [31:0] hi, lo;

    int cmp_cnt = 0;
    int err_cnt = 0;

    muldiv_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
        .hilo_req(hilo_req), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata), .flush(flush),
        .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference: {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (o)
            2'b00: begin p = sa * sb; return p; end
            2'b01: return ua * ub;
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic int model_busy(input logic [1:0] o, input logic [31:0] b);
        return (o[1] && b == 0) ? 1 : 33;
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rh, output logic [31:0] rl,
                          output int busy_n, output int done_at);
        @(negedge clk);
        start = 1'b1; op = o; srca = a; srcb = b;
        busy_n = 0;
        done_at = -1;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_n++;
            if (done) begin
                done_at = i;
                break;
            end
        end
        rh = hi;
        rl = lo;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 0; op = 0; srca = 0; srcb = 0;
        hilo_req = 0; wr_hi = 0; wr_lo = 0; wdata = 0; flush = 0;
        repeat (2) @(negedge clk);
        cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
        cmp_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL reset_done: got %b want 0", done); end
        cmp_cnt++; if (hi !== 32'h0) begin err_cnt++; $display("FAIL reset_hi: got %h want 0", hi); end
        cmp_cnt++; if (lo !== 32'h0) begin err_cnt++; $display("FAIL reset_lo: got %h want 0", lo); end
        reset = 1'b0;
    endtask

    task automatic test_mt_and_midreset();
        @(negedge clk);
        hilo_req = 1; wr_hi = 1; wr_lo = 1; wdata = 32'h1111_2222;
        @(negedge clk);
        hilo_req = 0; wr_hi = 0; wr_lo = 0;
        cmp_cnt++; if (hi !== 32'h1111_2222) begin err_cnt++; $display("FAIL mthi: got %h want 11112222", hi); end
        cmp_cnt++; if (lo !== 32'h1111_2222) begin err_cnt++; $display("FAIL mtlo: got %h want 11112222", lo); end
        start = 1; op = 2'b00; srca = 32'd123; srcb = 32'd456;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start = 0;
        end
        cmp_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL midreset_busy_before: got %b want 1", busy); end
        #2 reset = 1'b1;
        #1;
        cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL midreset_busy: got %b want 0", busy); end
        cmp_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL midreset_done: got %b want 0", done); end
        cmp_cnt++; if (hi !== 32'h0) begin err_cnt++; $display("FAIL midreset_hi: got %h want 0", hi); end
        cmp_cnt++; if (lo !== 32'h0) begin err_cnt++; $display("FAIL midreset_lo: got %h want 0", lo); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [1:0]  ops [5]  = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b10};
        logic [31:0] as  [5]  = '{32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h1234, 32'h8000_0000};
        logic [31:0] bs  [5]  = '{32'd6, 32'd5, 32'd2, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] ehi [5]  = '{32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234, 32'h0};
        logic [31:0] elo [5]  = '{32'h2A, 32'hFFFF_FFF1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
        int          ebusy[5] = '{33, 33, 33, 1, 33};
        logic [31:0] rh, rl;
        int bn, da;
        for (int k = 0; k < 5; k++) begin
            run_op(ops[k], as[k], bs[k], rh, rl, bn, da);
            cmp_cnt++; if (rl !== elo[k]) begin err_cnt++; $display("FAIL dir%0d_lo: got %h want %h", k, rl, elo[k]); end
            cmp_cnt++; if (rh !== ehi[k]) begin err_cnt++; $display("FAIL dir%0d_hi: got %h want %h", k, rh, ehi[k]); end
            cmp_cnt++; if (bn !== ebusy[k]) begin err_cnt++; $display("FAIL dir%0d_busy_cycles: got %0d want %0d", k, bn, ebusy[k]); end
            cmp_cnt++; if (da !== ebusy[k] + 1) begin err_cnt++; $display("FAIL dir%0d_done_cycle: got %0d want %0d", k, da, ebusy[k] + 1); end
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a, b, rh, rl;
        logic [63:0] exp;
        int bn, da;
        for (int k = 0; k < 24; k++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1, 2:    b = 32'($urandom_range(1, 15));
                3:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 300));
            exp = model(o, a, b);
            run_op(o, a, b, rh, rl, bn, da);
            cmp_cnt++; if ({rh, rl} !== exp) begin err_cnt++; $display("FAIL rand%0d op%0d a=%h b=%h: got %h_%h want %h", k, o, a, b, rh, rl, exp); end
            cmp_cnt++; if (bn !== model_busy(o, b)) begin err_cnt++; $display("FAIL rand%0d_busy_cycles: got %0d want %0d", k, bn, model_busy(o, b)); end
        end
    endtask

    task automatic test_flush();
        logic [31:0] lo_before;
        int dones;
        @(negedge clk);
        hilo_req = 1; wr_hi = 1; wdata = 32'h0000_AAAA;
        @(negedge clk);
        hilo_req = 0; wr_hi = 0;
        lo_before = lo;
        cmp_cnt++; if (hi !== 32'h0000_AAAA) begin err_cnt++; $display("FAIL flush_mthi: got %h want 0000aaaa", hi); end
        start = 1; op = 2'b01; srca = 32'd2; srcb = 32'd3;
        dones = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start = 0;
            if (done) dones++;
        end
        flush = 1;
        @(negedge clk);
        flush = 0;
        cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL flush_busy: got %b want 0", busy); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        cmp_cnt++; if (dones !== 0) begin err_cnt++; $display("FAIL flush_done_pulses: got %0d want 0", dones); end
        cmp_cnt++; if (hi !== 32'h0000_AAAA) begin err_cnt++; $display("FAIL flush_hi: got %h want 0000aaaa", hi); end
        cmp_cnt++; if (lo !== lo_before) begin err_cnt++; $display("FAIL flush_lo: got %h want %h", lo, lo_before); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, rh, rl, hi_hold, lo_hold;
        logic [63:0] exp1, exp2;
        int bad, stall_n, da;
        a1 = $urandom; b1 = $urandom | 32'h1;
        a2 = 32'($urandom_range(1, 1000)); b2 = $urandom;
        exp1 = model(2'b11, a1, b1);
        exp2 = model(2'b01, a2, b2);
        @(negedge clk);
        start = 1; op = 2'b11; srca = a1; srcb = b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            start = 0;
        end
        hi_hold = hi; lo_hold = lo;
        start = 1; op = 2'b01; srca = a2; srcb = b2;
        hilo_req = 1; wr_lo = 1; wdata = 32'h5555_5555;
        bad = 0; stall_n = 0;
        for (int i = 0; i < 80; i++) begin
            #1;
            if (!busy) break;
            stall_n++;
            if (stall !== 1'b1) bad++;
            if (hi !== hi_hold || lo !== lo_hold) bad++;
            @(negedge clk);
        end
        cmp_cnt++; if (bad !== 0) begin err_cnt++; $display("FAIL b2b_stall_hold: got %0d bad cycles want 0", bad); end
        cmp_cnt++; if (stall_n !== 29) begin err_cnt++; $display("FAIL b2b_stall_cycles: got %0d want 29", stall_n); end
        cmp_cnt++; if (done !== 1'b1) begin err_cnt++; $display("FAIL b2b_first_done: got %b want 1", done); end
        cmp_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL b2b_stall_release: got %b want 0", stall); end
        cmp_cnt++; if ({hi, lo} !== exp1) begin err_cnt++; $display("FAIL b2b_first_result: got %h_%h want %h", hi, lo, exp1); end
        @(negedge clk);
        start = 0; hilo_req = 0; wr_lo = 0;
        cmp_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL b2b_second_accept: got %b want 1", busy); end
        cmp_cnt++; if (lo !== exp1[31:0]) begin err_cnt++; $display("FAIL b2b_mtlo_dropped: got %h want %h", lo, exp1[31:0]); end
        da = -1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done) begin da = i; break; end
        end
        rh = hi; rl = lo;
        cmp_cnt++; if (da < 0) begin err_cnt++; $display("FAIL b2b_second_timeout: got no done want done"); end
        cmp_cnt++; if ({rh, rl} !== exp2) begin err_cnt++; $display("FAIL b2b_second_result: got %h_%h want %h", rh, rl, exp2); end
    endtask

    initial begin
        test_reset();
        test_mt_and_midreset();
        test_directed();
        test_random();
        test_flush();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
